// File: rtl/vec_mem_unit_pkg.sv
// Shared definitions for the CVP14 vector load/store stage: ISA opcodes,
// transfer state encoding and default geometry.
package vec_mem_unit_pkg;

  localparam int ELEMS_DEF = 16;
  localparam int DW_DEF    = 16;
  localparam int AW_DEF    = 16;

  typedef enum logic [3:0] {
    OP_VADD = 4'b0000,
    OP_VDOT = 4'b0001,
    OP_SMUL = 4'b0010,
    OP_SST4 = 4'b0011,
    OP_VLD  = 4'b0100,
    OP_VST  = 4'b0101,
    OP_SLL  = 4'b1000,
    OP_SLH  = 4'b1001,
    OP_BR   = 4'b1100,
    OP_NOP  = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DONE
  } state_e;

  // Only the two memory opcodes start a transfer; everything else is ignored.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_VLD) || (op == OP_VST);
  endfunction

endpackage

// File: rtl/vec_lane_sel.sv
// Combinational lane extract: picks element idx_i out of a packed vector,
// lane i occupying bits [DW*i +: DW].
module vec_lane_sel
  import vec_mem_unit_pkg::*;
#(
  parameter int ELEMS = ELEMS_DEF,
  parameter int DW    = DW_DEF,
  parameter int IW    = $clog2(ELEMS)
) (
  input  logic [ELEMS*DW-1:0] vec_i,
  input  logic [IW-1:0]       idx_i,
  output logic [DW-1:0]       lane_o
);

  // NOTE: assign a default before the loop so every path drives lane_o and no latch is inferred.
  always_comb begin
    lane_o = '0;
    for (int i = 0; i < ELEMS; i++) begin
      if (idx_i == IW'(i)) begin
        lane_o = vec_i[i*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/vec_mem_unit.sv
// Vector load/store stage: moves a ELEMS x DW vector to or from a DW-wide
// memory one element per accepted transaction, then pulses done.
module vec_mem_unit
  import vec_mem_unit_pkg::*;
#(
  parameter int ELEMS = ELEMS_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          opcode,
  input  logic [AW-1:0]       addr,
  input  logic [ELEMS*DW-1:0] wdata,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic                mem_rd,
  output logic                mem_wr,
  input  logic                mem_ready,
  input  logic [DW-1:0]       mem_rdata,
  output logic [ELEMS*DW-1:0] rdata,
  output logic                busy,
  output logic                done
);

  localparam int IW = $clog2(ELEMS);

  state_e              state_q,   state_d;
  logic [IW-1:0]       idx_q,     idx_d;
  logic                is_load_q, is_load_d;
  logic [AW-1:0]       base_q,    base_d;
  logic [ELEMS*DW-1:0] wvec_q,    wvec_d;
  logic [ELEMS*DW-1:0] rdata_q,   rdata_d;
  logic [DW-1:0]       store_lane;

  vec_lane_sel #(
    .ELEMS (ELEMS),
    .DW    (DW),
    .IW    (IW)
  ) u_lane_sel (
    .vec_i  (wvec_q),
    .idx_i  (idx_q),
    .lane_o (store_lane)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    is_load_d = is_load_q;
    base_d    = base_q;
    wvec_d    = wvec_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && is_mem_op(opcode)) begin
          is_load_d = (opcode == OP_VLD);
          base_d    = addr;
          wvec_d    = wdata;
          idx_d     = '0;
          state_d   = ST_XFER;
        end
      end

      ST_XFER: begin
        if (mem_ready) begin
          if (is_load_q) begin
            for (int i = 0; i < ELEMS; i++) begin
              if (idx_q == IW'(i)) begin
                rdata_d[i*DW +: DW] = mem_rdata;
              end
            end
          end
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(ELEMS - 1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // rdata is architecturally visible and must read zero after reset, so the
  // vector registers are reset along with the control state.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      is_load_q <= 1'b0;
      base_q    <= '0;
      wvec_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      is_load_q <= is_load_d;
      base_q    <= base_d;
      wvec_q    <= wvec_d;
      rdata_q   <= rdata_d;
    end
  end

  // Memory strobes decode registered state only; mem_ready never feeds them.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    if (state_q == ST_XFER) begin
      mem_addr  = base_q + AW'(idx_q);
      mem_rd    = is_load_q;
      mem_wr    = !is_load_q;
      mem_wdata = is_load_q ? '0 : store_lane;
    end
  end

  assign rdata = rdata_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_vec_mem_unit.sv
// Scoreboard bench for vec_mem_unit: stimulus pushes expected memory
// transactions and completions; a negedge monitor pops and compares them.
module tb_vec_mem_unit;
  import vec_mem_unit_pkg::*;

  localparam int ELEMS = 16;
  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int VW    = ELEMS * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    opcode;
  logic [AW-1:0] addr;
  logic [VW-1:0] wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic [VW-1:0] rdata;
  logic          busy;
  logic          done;

  vec_mem_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .opcode    (opcode),
    .addr      (addr),
    .wdata     (wdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: reads return the address; ready drops in a programmed window.
  int stall_lo = -1;
  int stall_hi = -2;
  assign mem_ready = !(cyc >= stall_lo && cyc <= stall_hi);
  assign mem_rdata = mem_addr;

  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } txn_t;

  typedef struct {
    int            at_cyc;
    logic [VW-1:0] rd;
  } done_t;

  txn_t  exp_txn[$];
  done_t exp_done[$];
  logic [VW-1:0] exp_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  logic          prev_pend = 1'b0;
  logic [AW-1:0] prev_a;
  logic [DW-1:0] prev_d;
  logic          prev_rd;
  logic          prev_wr;

  always @(negedge clk) begin
    if (rst) begin
      prev_pend = 1'b0;
    end else begin
      check("rd_wr_exclusive", VW'(mem_rd & mem_wr), '0);
      if (prev_pend) begin
        check("stall_hold_addr", VW'(mem_addr), VW'(prev_a));
        check("stall_hold_wdata", VW'(mem_wdata), VW'(prev_d));
        check("stall_hold_strobes", VW'({mem_rd, mem_wr}), VW'({prev_rd, prev_wr}));
      end
      if ((mem_rd || mem_wr) && mem_ready) begin
        check("txn_expected", VW'(exp_txn.size() > 0), VW'(1));
        if (exp_txn.size() > 0) begin
          txn_t t;
          t = exp_txn.pop_front();
          check("txn_wr", VW'(mem_wr), VW'(t.wr));
          check("txn_rd", VW'(mem_rd), VW'(!t.wr));
          check("txn_addr", VW'(mem_addr), VW'(t.a));
          check("txn_wdata", VW'(mem_wdata), VW'(t.d));
        end
      end
      prev_pend = (mem_rd || mem_wr) && !mem_ready;
      prev_a    = mem_addr;
      prev_d    = mem_wdata;
      prev_rd   = mem_rd;
      prev_wr   = mem_wr;

      if (done) begin
        check("done_expected", VW'(exp_done.size() > 0), VW'(1));
        if (exp_done.size() > 0) begin
          done_t e;
          e = exp_done.pop_front();
          check("done_cycle", VW'(cyc), VW'(e.at_cyc));
          check("done_rdata", rdata, e.rd);
          check("done_busy", VW'(busy), VW'(1));
          check("done_strobes_low", VW'({mem_rd, mem_wr}), '0);
        end
      end
    end
  end

  // Issue one instruction at a negedge; stalls drop ready on element 5.
  task automatic issue(input logic [3:0] op, input logic [AW-1:0] a,
                       input logic [VW-1:0] wv, input int stalls);
    int s;
    s        = cyc;
    opcode   = op;
    addr     = a;
    wdata    = wv;
    start    = 1'b1;
    stall_lo = -1;
    stall_hi = -2;
    if (stalls > 0) begin
      stall_lo = s + 6;
      stall_hi = s + 5 + stalls;
    end
    if (op == OP_VLD || op == OP_VST) begin
      for (int i = 0; i < ELEMS; i++) begin
        txn_t t;
        t.wr = (op == OP_VST);
        t.a  = a + AW'(i);
        t.d  = (op == OP_VST) ? wv[i*DW +: DW] : '0;
        exp_txn.push_back(t);
        if (op == OP_VLD) exp_rdata[i*DW +: DW] = a + AW'(i);
      end
      exp_done.push_back('{s + 17 + stalls, exp_rdata});
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 60 && !done; k++) @(negedge clk);
    check({name, "_done_seen"}, VW'(done), VW'(1));
    @(negedge clk);
    check({name, "_busy_after"}, VW'(busy), '0);
    check({name, "_txn_drained"}, VW'(exp_txn.size()), '0);
  endtask

  initial begin
    logic [VW-1:0] wv;
    rst    = 1'b1;
    start  = 1'b0;
    opcode = '0;
    addr   = '0;
    wdata  = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_rd", VW'(mem_rd), '0);
    check("rst_mem_wr", VW'(mem_wr), '0);
    check("rst_mem_addr", VW'(mem_addr), '0);
    check("rst_mem_wdata", VW'(mem_wdata), '0);
    check("rst_rdata", rdata, '0);
    check("rst_busy_done", VW'({busy, done}), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    issue(OP_VLD, 16'h0010, '0, 0);
    wait_done("vld_basic");

    for (int i = 0; i < ELEMS; i++) wv[i*DW +: DW] = 16'hA000 + DW'(i);
    issue(OP_VST, 16'h0100, wv, 0);
    wait_done("vst_basic");

    issue(OP_VLD, 16'h0300, '0, 3);
    wait_done("vld_stall");

    issue(OP_VLD, 16'hFFF8, '0, 0);
    wait_done("vld_wrap");

    issue(OP_VADD, 16'h0777, '1, 0);
    repeat (3) begin
      check("vadd_idle_busy", VW'(busy), '0);
      check("vadd_no_strobes", VW'({mem_rd, mem_wr}), '0);
      @(negedge clk);
    end

    issue(OP_VLD, 16'h0040, '0, 0);
    repeat (5) @(negedge clk);
    opcode = OP_VST;
    addr   = 16'h0900;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done("vld_start_ignored");
    repeat (4) @(negedge clk);

    // Abort a load after element 7 has been accepted (edge E8).
    issue(OP_VLD, 16'h0200, '0, 0);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_mem_rd", VW'(mem_rd), '0);
    check("abort_busy", VW'(busy), '0);
    check("abort_rdata", rdata, '0);
    exp_txn.delete();
    exp_done.delete();
    exp_rdata = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    issue(OP_VLD, 16'h0500, '0, 0);
    wait_done("vld_after_abort");

    repeat (3) @(negedge clk);
    check("final_done_drained", VW'(exp_done.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
